// File: rtl/debug_dump_tx.sv
// rtl/debug_dump_tx.sv - debug-unit transmit engine that streams PC, registers and data memory to the UART
//
// On an accepted start request the PC is captured and the engine sends one
// stream of words: PC, reg[0..N_REGS-1], mem[0..N_MEM-1]. Each word goes out
// as DATA_WIDTH/DATA_WIDTH_UART bytes, least-significant byte first.
//
// Ports:
//   i_clock, i_reset          clock, asynchronous active-high reset
//   i_start, i_pc             one-cycle dump request and the PC sampled with it
//   o_reg_addr, i_reg_data    register-file debug read port (data one cycle after address)
//   o_mem_addr, i_mem_data    data-memory debug read port (data one cycle after address)
//   i_tx_available, i_tx_done UART idle flag and end-of-byte pulse
//   o_tx_signal, o_tx_result  one-cycle send pulse and the byte, held until i_tx_done
//   o_busy, o_done            dump in progress, one-cycle completion pulse
module debug_dump_tx #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_WIDTH_UART = 8,
  parameter int N_REGS          = 32,
  parameter int N_MEM           = 32
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [DATA_WIDTH-1:0]      i_pc,
  output logic [4:0]                 o_reg_addr,
  input  logic [DATA_WIDTH-1:0]      i_reg_data,
  output logic [4:0]                 o_mem_addr,
  input  logic [DATA_WIDTH-1:0]      i_mem_data,
  input  logic                       i_tx_available,
  input  logic                       i_tx_done,
  output logic                       o_tx_signal,
  output logic [DATA_WIDTH_UART-1:0] o_tx_result,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int LAST  = N_REGS + N_MEM;
  localparam int IDXW  = $clog2(LAST + 1);
  localparam int BYTES = DATA_WIDTH / DATA_WIDTH_UART;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_LATCH     = 3'd2;
  localparam logic [2:0] S_WAIT_TX   = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]            state;
  logic [IDXW-1:0]       word_idx;
  logic [BW-1:0]         byte_idx;
  logic [DATA_WIDTH-1:0] buffer;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_IDLE;
      word_idx    <= '0;
      byte_idx    <= '0;
      buffer      <= '0;
      o_reg_addr  <= '0;
      o_mem_addr  <= '0;
      o_tx_signal <= 1'b0;
      o_tx_result <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_tx_signal <= 1'b0;
      o_done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            buffer   <= i_pc;
            word_idx <= '0;
            byte_idx <= '0;
            o_busy   <= 1'b1;
            state    <= S_WAIT_TX;
          end
        end
        // The read address is registered on entry to FETCH so it is stable for
        // the whole FETCH cycle; the synchronous read data is then valid while
        // in LATCH.
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          buffer   <= (word_idx <= IDXW'(N_REGS)) ? i_reg_data : i_mem_data;
          byte_idx <= '0;
          state    <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (i_tx_available) begin
            o_tx_result <= buffer[32'(byte_idx) * DATA_WIDTH_UART +: DATA_WIDTH_UART];
            o_tx_signal <= 1'b1;
            state       <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (i_tx_done) begin
            if (byte_idx != BW'(BYTES - 1)) begin
              byte_idx <= byte_idx + 1'b1;
              state    <= S_WAIT_TX;
            end else if (word_idx != IDXW'(LAST)) begin
              // Next word index is word_idx+1: reg[word_idx] while word_idx < N_REGS,
              // otherwise mem[word_idx-N_REGS].
              word_idx <= word_idx + 1'b1;
              if (word_idx < IDXW'(N_REGS))
                o_reg_addr <= 5'(word_idx);
              else
                o_mem_addr <= 5'(word_idx - IDXW'(N_REGS));
              state <= S_FETCH;
            end else begin
              o_done <= 1'b1;
              o_busy <= 1'b0;
              state  <= S_DONE;
            end
          end
        end
        // One cycle with o_done high; a start request here is not looked at.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_dump_tx.sv
// tb/tb_debug_dump_tx.sv - self-checking bench for debug_dump_tx
module tb_debug_dump_tx;

  logic        clk, rst, start, avail, txd;
  logic [31:0] pc, reg_data, mem_data;
  logic [4:0]  reg_addr, mem_addr;
  logic        tsig, busy, done;
  logic [7:0]  tres;

  debug_dump_tx dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_pc(pc),
    .o_reg_addr(reg_addr), .i_reg_data(reg_data),
    .o_mem_addr(mem_addr), .i_mem_data(mem_data),
    .i_tx_available(avail), .i_tx_done(txd),
    .o_tx_signal(tsig), .o_tx_result(tres), .o_busy(busy), .o_done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] reg_mem [32];
  logic [31:0] dmem [32];
  always @(posedge clk) begin
    reg_data <= reg_mem[reg_addr];
    mem_data <= dmem[mem_addr];
  end

  int         checks = 0, errors = 0;
  logic [7:0] cap[$], ref1[$];
  int         done_cnt = 0, sig_bad = 0, stab_bad = 0, tx_cnt = 0, dly_mode = 0;
  time        t_done4 = 0, t_sig5 = 0;
  logic       avail_q = 1'b1;

  typedef struct {
    int         scen;
    int         pos;
    logic [7:0] exp;
    string      name;
  } vec_t;
  vec_t vecs[$];

  always @(posedge clk) avail_q <= avail;

  always @(negedge clk) begin
    if (tsig) begin
      cap.push_back(tres);
      if (!avail_q) sig_bad++;
      if (cap.size() == 5) t_sig5 = $time;
    end
    if (done) done_cnt++;
  end

  // UART model: answers each send pulse with i_tx_done after a delay and
  // watches that the byte stays put meanwhile.
  logic [7:0] tx_b;
  int         tx_d;
  bit         tx_ab;
  initial begin
    txd = 1'b0;
    forever begin
      @(negedge clk);
      if (tsig && !rst) begin
        tx_b = tres;
        tx_cnt++;
        if (dly_mode == 0) tx_d = 10;
        else if (tx_cnt % 32 == 1) tx_d = int'($urandom_range(2000, 1));
        else tx_d = int'($urandom_range(20, 1));
        tx_ab = 1'b0;
        for (int k = 0; k < tx_d; k++) begin
          @(negedge clk);
          if (rst) tx_ab = 1'b1;
          else if (tres !== tx_b) stab_bad++;
        end
        if (!tx_ab) begin
          txd = 1'b1;
          if (tx_cnt == 4) t_done4 = $time;
          @(negedge clk);
          txd = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int n, input logic [31:0] p);
    int          w;
    logic [31:0] v;
    w = n / 4;
    if (w == 0) v = p;
    else if (w <= 32) v = reg_mem[w - 1];
    else v = dmem[w - 33];
    return v[8 * (n % 4) +: 8];
  endfunction

  task automatic chk_stream(input string name, input logic [31:0] p);
    int bad = 0;
    for (int n = 0; n < cap.size(); n++)
      if (cap[n] !== exp_byte(n, p)) bad++;
    chk(name, bad, 0);
  endtask

  task automatic chk_same(input string name);
    int bad = 0;
    if (cap.size() != ref1.size()) bad = 1000;
    else for (int n = 0; n < cap.size(); n++) if (cap[n] !== ref1[n]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic apply_vecs(input int scen);
    logic [8:0] act;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].scen == scen) begin
        act = (vecs[i].pos < cap.size()) ? {1'b0, cap[vecs[i].pos]} : 9'h1FF;
        chk(vecs[i].name, act, {1'b0, vecs[i].exp});
      end
    end
  endtask

  task automatic clear_obs();
    cap.delete();
    done_cnt = 0;
    sig_bad  = 0;
    stab_bad = 0;
    tx_cnt   = 0;
  endtask

  task automatic pulse_start(input logic [31:0] p);
    @(posedge clk); #1;
    pc    = p;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    for (int k = 0; k < budget && cap.size() < n; k++) @(negedge clk);
    if (cap.size() < n) chk("wait_bytes_timeout", cap.size(), n);
  endtask

  task automatic wait_done(input int budget, input bit start_on_done);
    bit got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    else if (start_on_done) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; avail = 1'b1; pc = '0;
    for (int k = 0; k < 32; k++) begin
      reg_mem[k] = 32'h100 + k;
      dmem[k]    = 32'hA000_0000 + k;
    end
    reg_mem[5] = 32'h1122_3344;

    vecs.push_back('{1,   0, 8'h0D, "s1_pc_b0"});
    vecs.push_back('{1,   1, 8'h00, "s1_pc_b1"});
    vecs.push_back('{1,   2, 8'h00, "s1_pc_b2"});
    vecs.push_back('{1,   3, 8'h00, "s1_pc_b3"});
    vecs.push_back('{1,   4, 8'h00, "s1_r0_b0"});
    vecs.push_back('{1,   5, 8'h01, "s1_r0_b1"});
    vecs.push_back('{1,   6, 8'h00, "s1_r0_b2"});
    vecs.push_back('{1,   7, 8'h00, "s1_r0_b3"});
    vecs.push_back('{1,  24, 8'h44, "s1_r5_b0"});
    vecs.push_back('{1,  25, 8'h33, "s1_r5_b1"});
    vecs.push_back('{1,  26, 8'h22, "s1_r5_b2"});
    vecs.push_back('{1,  27, 8'h11, "s1_r5_b3"});
    vecs.push_back('{1,  12, 8'h02, "s1_r2_b0"});
    vecs.push_back('{1, 132, 8'h00, "s1_m0_b0"});
    vecs.push_back('{1, 135, 8'hA0, "s1_m0_b3"});
    vecs.push_back('{1, 256, 8'h1F, "s1_m31_b0"});
    vecs.push_back('{1, 257, 8'h00, "s1_m31_b1"});
    vecs.push_back('{1, 258, 8'h00, "s1_m31_b2"});
    vecs.push_back('{1, 259, 8'hA0, "s1_m31_b3"});
    vecs.push_back('{3,   0, 8'h0D, "s3_pc_kept"});
    vecs.push_back('{5,   0, 8'h20, "s5_pc_b0"});
    vecs.push_back('{5,   1, 8'h00, "s5_pc_b1"});
    vecs.push_back('{5,   2, 8'h00, "s5_pc_b2"});
    vecs.push_back('{5,   3, 8'h00, "s5_pc_b3"});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {tsig, tres, busy, done, reg_addr, mem_addr}, '0);
    rst = 1'b0;

    // Full dump, fixed UART latency.
    clear_obs();
    dly_mode = 0;
    pulse_start(32'h0000_000D);
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_sig_not_yet", tsig, 0);
    @(negedge clk);
    chk("start_first_sig", tsig, 1);
    wait_done(60000, 1'b0);
    repeat (5) @(negedge clk);
    chk("s1_len", cap.size(), 260);
    chk("s1_done_cnt", done_cnt, 1);
    chk("s1_busy_after", busy, 0);
    chk("s1_word_gap", (t_sig5 - t_done4) / 10, 4);
    chk("s1_stable", stab_bad, 0);
    chk_stream("s1_stream", 32'h0000_000D);
    apply_vecs(1);
    ref1 = cap;

    // Backpressure with a stray i_tx_done during the stall.
    clear_obs();
    dly_mode = 1;
    avail = 1'b0;
    pulse_start(32'h0000_000D);
    repeat (250) @(posedge clk);
    #1 txd = 1'b1;
    @(posedge clk);
    #1 txd = 1'b0;
    repeat (250) @(posedge clk);
    #1;
    chk("s2_stall_quiet", cap.size(), 0);
    avail = 1'b1;
    wait_done(60000, 1'b0);
    repeat (5) @(negedge clk);
    chk("s2_len", cap.size(), 260);
    chk("s2_done_cnt", done_cnt, 1);
    chk("s2_sig_while_unavail", sig_bad, 0);
    chk("s2_stable", stab_bad, 0);
    chk_same("s2_same_as_s1");

    // Stray i_tx_done in IDLE, then start while busy.
    clear_obs();
    dly_mode = 0;
    @(posedge clk);
    #1 txd = 1'b1;
    @(posedge clk);
    #1 txd = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_txdone_ignored", {busy, 9'(cap.size())}, 0);
    pulse_start(32'h0000_000D);
    wait_bytes(40, 5000);
    pulse_start(32'h0000_0055);
    wait_done(60000, 1'b0);
    repeat (5) @(negedge clk);
    chk("s3_len", cap.size(), 260);
    chk("s3_done_cnt", done_cnt, 1);
    chk_same("s3_same_as_s1");
    apply_vecs(3);

    // Reset mid-dump.
    clear_obs();
    pulse_start(32'h0000_000D);
    wait_bytes(100, 10000);
    chk("s4_busy_before_rst", busy, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("s4_rst_outputs", {tsig, tres, busy, done, reg_addr, mem_addr}, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("s4_no_done", done_cnt, 0);
    chk("s4_idle_after", busy, 0);

    // Fresh dump after reset; PC changes right after start; start during DONE.
    clear_obs();
    pulse_start(32'h0000_0020);
    pc = 32'h0000_0077;
    wait_done(60000, 1'b1);
    repeat (20) @(negedge clk);
    chk("s5_len", cap.size(), 260);
    chk("s5_done_cnt", done_cnt, 1);
    chk("s5_start_in_done_ignored", busy, 0);
    chk_stream("s5_stream", 32'h0000_0020);
    apply_vecs(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
